// File: rtl/axi_ram_slave.sv
// Single-beat AXI RAM slave: 64-bit word memory with independent read and write FSMs.
// Responses are OKAY, SLVERR (bad size or misaligned) or DECERR (out of range).
module axi_ram_slave #(
    parameter int unsigned DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        s_axi_rlast,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);
    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [32:0] SPAN        = 33'(DEPTH) << 3;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } w_t;

    // Range check first, then size/alignment.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] size);
        logic [32:0] off;
        logic [2:0]  mask;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        case (size)
            3'd1:    mask = 3'b001;
            3'd2:    mask = 3'b011;
            3'd3:    mask = 3'b111;
            default: mask = 3'b000;
        endcase
        if (off >= SPAN)
            classify = RESP_DECERR;
        else if (size > 3'd3 || (addr[2:0] & mask) != 3'b000)
            classify = RESP_SLVERR;
        else
            classify = RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        word_idx = IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem [DEPTH];

    w_state_e   w_state, w_next;
    r_state_e   r_state, r_next;
    aw_t        aw_q;
    w_t         w_q;
    logic       aw_held, w_held;
    logic [1:0] bresp_q;
    logic [63:0] rdata_q;
    logic [1:0] rresp_q;

    logic             aw_hs_c, w_hs_c, ar_hs_c, we_c;
    logic [1:0]       wresp_c, rresp_c;
    logic [IDX_W-1:0] w_idx_c, r_idx_c;

    // Readies are gated by reset so they drop immediately and rise on the first cycle after release.
    assign s_axi_awready = i_rstn && (w_state == W_IDLE) && !aw_held;
    assign s_axi_wready  = i_rstn && (w_state == W_IDLE) && !w_held;
    assign s_axi_arready = i_rstn && (r_state == R_IDLE);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rlast   = (r_state == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign aw_hs_c = s_axi_awvalid && s_axi_awready;
    assign w_hs_c  = s_axi_wvalid && s_axi_wready;
    assign ar_hs_c = s_axi_arvalid && s_axi_arready;
    assign wresp_c = classify(aw_q.addr, aw_q.size);
    assign rresp_c = classify(s_axi_araddr, s_axi_arsize);
    assign w_idx_c = word_idx(aw_q.addr);
    assign r_idx_c = word_idx(s_axi_araddr);
    assign we_c    = i_rstn && (w_state == W_COMMIT) && (wresp_c == RESP_OKAY);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:   if ((aw_held || aw_hs_c) && (w_held || w_hs_c)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (s_axi_bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (ar_hs_c) r_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // One-entry AW/W holding registers and the latched write response.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            aw_q    <= '0;
            w_q     <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else if (w_state == W_COMMIT) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wresp_c;
        end else begin
            if (aw_hs_c) begin
                aw_held <= 1'b1;
                aw_q    <= '{addr: s_axi_awaddr, size: s_axi_awsize};
            end
            if (w_hs_c) begin
                w_held <= 1'b1;
                w_q    <= '{data: s_axi_wdata, strb: s_axi_wstrb};
            end
        end
    end

    // Read data register; a same-edge commit is not yet visible here.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs_c) begin
            rresp_q <= rresp_c;
            rdata_q <= (rresp_c == RESP_DECERR) ? 64'd0 : mem[r_idx_c];
        end
    end

    always_ff @(posedge i_clk) begin
        if (we_c) begin
            for (int b = 0; b < 8; b++) begin
                if (w_q.strb[b]) mem[w_idx_c][8*b +: 8] <= w_q.data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi_ram_slave;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awsize, arsize;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int tests = 0;
    int fails = 0;
    int nb = 0;
    int nr = 0;
    logic [1:0]  exp_b[$];
    logic [65:0] exp_r[$];
    logic [65:0] r_exp;

    axi_ram_slave dut (
        .i_clk(clk), .i_rstn(rstn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awsize(awsize),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arsize(arsize),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rlast(rlast),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rstn && bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected_queue_depth", 64'(exp_b.size()), 64'd1);
            else chk("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            nb++;
        end
        if (rstn && rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected_queue_depth", 64'(exp_r.size()), 64'd1);
            else begin
                r_exp = exp_r.pop_front();
                chk("rdata", rdata, r_exp[65:2]);
                chk("rresp", 64'(rresp), 64'(r_exp[1:0]));
                chk("rlast", 64'(rlast), 64'd1);
            end
            nr++;
        end
    end

    task automatic wait_b(input int target);
        for (int n = 0; n < 40 && nb < target; n++) tick();
        chk("b_response_count", 64'(nb), 64'(target));
    endtask

    task automatic wait_r(input int target);
        for (int n = 0; n < 40 && nr < target; n++) tick();
        chk("r_response_count", 64'(nr), 64'(target));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                             input logic [7:0] st, input logic [1:0] exp);
        int  tgt;
        logic a_hs, d_hs;
        exp_b.push_back(exp);
        tgt = nb + 1;
        awaddr = a; awsize = sz; wdata = d; wstrb = st;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            @(negedge clk);
            a_hs = awvalid && awready;
            d_hs = wvalid && wready;
            tick();
            if (a_hs) awvalid = 1'b0;
            if (d_hs) wvalid = 1'b0;
        end
        chk("aw_w_accepted", 64'({awvalid, wvalid}), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_b(tgt);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [2:0] sz,
                            input logic [63:0] d, input logic [1:0] exp);
        int  tgt;
        logic hs;
        exp_r.push_back({d, exp});
        tgt = nr + 1;
        araddr = a; arsize = sz; arvalid = 1'b1;
        for (int i = 0; i < 20 && arvalid; i++) begin
            @(negedge clk);
            hs = arvalid && arready;
            tick();
            if (hs) arvalid = 1'b0;
        end
        chk("ar_accepted", 64'(arvalid), 64'd0);
        arvalid = 1'b0;
        wait_r(tgt);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb_tgt, tr_tgt;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; araddr = 0; awsize = 0; arsize = 0; wdata = 0; wstrb = 0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid_rlast", 64'({rvalid, rlast}), 64'd0);
        chk("rst_bresp_rresp", 64'({bresp, rresp}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("release_readies", 64'({awready, wready, arready}), 64'b111);
        tick();

        // Full word write and readback, then a single byte lane update.
        axi_write(32'h10, 3'd3, 64'h1122334455667788, 8'hFF, 2'b00);
        axi_read (32'h10, 3'd3, 64'h1122334455667788, 2'b00);
        axi_write(32'h13, 3'd0, 64'h00000000AB000000, 8'h08, 2'b00);
        axi_read (32'h10, 3'd3, 64'h11223344AB667788, 2'b00);

        // W leads AW by three cycles; response held with bready low.
        exp_b.push_back(2'b00);
        tb_tgt = nb + 1;
        bready = 1'b0;
        wdata = 64'hCAFEF00D12345678; wstrb = 8'hFF; wvalid = 1'b1;
        @(negedge clk);
        chk("skew_c0_wready", 64'(wready), 64'd1);
        tick();
        wvalid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("skew_wait_rdy_bvalid", 64'({awready, wready, bvalid}), 64'b100);
            tick();
        end
        awaddr = 32'h18; awsize = 3'd3; awvalid = 1'b1;
        @(negedge clk);
        chk("skew_c3_awready", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        chk("skew_c4_commit", 64'({awready, wready, bvalid}), 64'b000);
        tick();
        for (int c = 5; c < 9; c++) begin
            @(negedge clk);
            chk("skew_resp_hold", 64'({awready, wready, bvalid, bresp}), 64'b00100);
            tick();
        end
        bready = 1'b1;
        wait_b(tb_tgt);
        axi_read(32'h18, 3'd3, 64'hCAFEF00D12345678, 2'b00);

        // Out of range: DECERR on both sides, aliasing word untouched.
        axi_write(32'h0, 3'd3, 64'h0F0E0D0C0B0A0908, 8'hFF, 2'b00);
        axi_write(32'h1000, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b11);
        axi_read (32'h1000, 3'd3, 64'd0, 2'b11);
        axi_read (32'h0, 3'd3, 64'h0F0E0D0C0B0A0908, 2'b00);

        // Misalignment and illegal size give SLVERR without writing.
        axi_write(32'h12, 3'd2, 64'hFFFFFFFFFFFFFFFF, 8'h3C, 2'b10);
        axi_read (32'h10, 3'd3, 64'h11223344AB667788, 2'b00);
        axi_read (32'h14, 3'd3, 64'h11223344AB667788, 2'b10);
        axi_write(32'h20, 3'd4, 64'h1, 8'hFF, 2'b10);

        // Upper-lane partial write.
        axi_write(32'h4, 3'd2, 64'hDEADBEEF00000000, 8'hF0, 2'b00);
        axi_read (32'h0, 3'd3, 64'hDEADBEEF0B0A0908, 2'b00);

        // Read accepted on the commit edge sees the old word.
        exp_b.push_back(2'b00);
        exp_r.push_back({64'h11223344AB667788, 2'b00});
        tb_tgt = nb + 1; tr_tgt = nr + 1;
        awaddr = 32'h10; awsize = 3'd3; wdata = 64'h5555AAAA5555AAAA; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h10; arsize = 3'd3; arvalid = 1'b1;
        @(negedge clk);
        chk("same_edge_arready", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        wait_b(tb_tgt);
        wait_r(tr_tgt);
        axi_read(32'h10, 3'd3, 64'h5555AAAA5555AAAA, 2'b00);

        // Reset during W_COMMIT drops the write.
        awaddr = 32'h10; awsize = 3'd3; wdata = 64'h9999999999999999; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("commit_readies_low", 64'({awready, wready}), 64'b00);
        rstn = 1'b0;
        #1;
        chk("midrst_immediate", 64'({bvalid, awready, wready, arready}), 64'b0000);
        tick();
        chk("midrst_bvalid", 64'(bvalid), 64'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_release_readies", 64'({awready, wready, arready, bvalid}), 64'b1110);
        tick();
        axi_read(32'h10, 3'd3, 64'h5555AAAA5555AAAA, 2'b00);

        repeat (2) tick();
        chk("exp_b_drained", 64'(exp_b.size()), 64'd0);
        chk("exp_r_drained", 64'(exp_r.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
